// File: rtl/axi_lite_uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_uart_bridge_pkg
// Brief    : Shared types and constants for the AXI4-Lite to UART bridge.
// Revision : 1.0
// ============================================================================
package axi_lite_uart_bridge_pkg;

    localparam int         UART_IDX_W  = 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_RESP  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_RESP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_uart_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_uart_bridge
// Brief    : AXI4-Lite slave driving the 16550 register bus with one-cycle
//            rd/we strobes. Optional macro AXI_LITE_UART_BRIDGE_WSTRB_CHECK_EN
//            rejects writes whose UART byte lane strobe is clear (SLVERR).
// Revision : 1.0
// ============================================================================
module axi_lite_uart_bridge
    import axi_lite_uart_bridge_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int REG_SHIFT = 2,
    parameter int LENDIAN   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [UART_IDX_W-1:0] a,
    output logic [31:0]           d,
    output logic                  rd,
    output logic                  we,
    input  logic [31:0]           spo,
    input  logic                  ready
);

    localparam int c_LANE = (LENDIAN != 0) ? 0 : 3;

    state_t                r_state;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [UART_IDX_W-1:0] r_aw_idx;
    logic [UART_IDX_W-1:0] r_a;
    logic [31:0]           r_d;
    logic [31:0]           r_rdata;
    logic                  r_lane_ok;
    logic                  r_bvalid;
    logic                  r_rvalid;
    logic [1:0]            r_bresp;

    logic                  w_idle;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_wr_go;
    logic                  w_issue_ok;
    logic [UART_IDX_W-1:0] w_aw_idx;
    logic [UART_IDX_W-1:0] w_ar_idx;
    logic                  w_unused_bits;

    assign w_idle        = (r_state == IDLE);
    assign s_axi_awready = w_idle && !r_aw_held;
    assign s_axi_wready  = w_idle && !r_w_held;
    // Reads stay blocked while any write beat is offered or held: writes win.
    assign s_axi_arready = w_idle && !r_aw_held && !r_w_held
                           && !s_axi_awvalid && !s_axi_wvalid;

    assign w_aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_w_hs   = s_axi_wvalid  && s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid && s_axi_arready;
    assign w_wr_go  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_aw_idx = s_axi_awaddr[REG_SHIFT+UART_IDX_W-1:REG_SHIFT];
    assign w_ar_idx = s_axi_araddr[REG_SHIFT+UART_IDX_W-1:REG_SHIFT];

`ifdef AXI_LITE_UART_BRIDGE_WSTRB_CHECK_EN
    assign w_issue_ok = r_lane_ok;
`else
    assign w_issue_ok = 1'b1;
`endif

    assign w_unused_bits = ^{s_axi_awaddr, s_axi_araddr, s_axi_wstrb, r_lane_ok};

    // Strobes are decoded from state and ready so they land the cycle after
    // the accept and can never repeat once the FSM leaves the ISSUE state.
    assign we = (r_state == WR_ISSUE) && ready && w_issue_ok;
    assign rd = (r_state == RD_ISSUE) && ready;

    assign a            = r_a;
    assign d            = r_d;
    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = RESP_OKAY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_a       <= '0;
            r_d       <= '0;
            r_rdata   <= '0;
            r_lane_ok <= 1'b0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_aw_idx  <= w_aw_idx;
                    end
                    if (w_w_hs) begin
                        r_w_held  <= 1'b1;
                        r_d       <= s_axi_wdata;
                        r_lane_ok <= s_axi_wstrb[c_LANE];
                    end
                    if (w_wr_go) begin
                        r_state <= WR_ISSUE;
                        r_a     <= w_aw_hs ? w_aw_idx : r_aw_idx;
                    end else if (w_ar_hs) begin
                        r_state <= RD_ISSUE;
                        r_a     <= w_ar_idx;
                    end
                end
                WR_ISSUE: begin
                    if (!w_issue_ok) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bresp   <= RESP_SLVERR;
                        r_bvalid  <= 1'b1;
                        r_state   <= WR_RESP;
                    end else if (ready) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_bvalid  <= 1'b1;
                        r_state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    // spo is captured alongside rd, before the UART FIFO pops.
                    if (ready) begin
                        r_rdata  <= spo;
                        r_rvalid <= 1'b1;
                        r_state  <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_axi_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_uart_bridge.md
Name: axi_lite_uart_bridge

Overview:
AXI4-Lite slave that converts AXI register transactions into the UART core's simple register bus (a, d, rd, we, spo, ready). It sits directly upstream of the 16550 UART core in the Axi16550 IP. It guarantees single-cycle rd/we strobes, because UART reads have side effects (RBR read pops the RX FIFO; IIR read clears THRE irq; LSR read clears OE).
- One transaction is in flight at a time.
- Writes win over reads when both are pending in the same cycle.

Parameters:
- ADDR_W, 5: AXI address width.
- REG_SHIFT, 2: register index = addr[REG_SHIFT+2:REG_SHIFT]; 2 means word-spaced registers.
- LENDIAN, 0: byte lane used by the UART. 0 means bits [31:24]; 1 means bits [7:0]. Must match the UART core's setting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write-address handshake
- s_axi_wdata  in  32 / s_axi_wstrb  in  4  write data and byte strobes
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write-data handshake
- s_axi_bresp  out  2 / s_axi_bvalid  out  1 / s_axi_bready  in  1  write response
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read-address handshake
- s_axi_rdata  out  32 / s_axi_rresp  out  2 / s_axi_rvalid  out  1 / s_axi_rready  in  1  read response
- a  out  3  UART register index
- d  out  32  UART write data, wdata passed through unmodified
- rd  out  1  UART read strobe, exactly one cycle
- we  out  1  UART write strobe, exactly one cycle
- spo  in  32  UART read data, combinational from a
- ready  in  1  UART ready; strobes are only issued when high

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State IDLE; awready=wready=arready=1.
  - bvalid=rvalid=0; bresp=rresp=0; rdata=0.
  - rd=we=0; a=0; d=0.
  - aw_held=w_held=0.
- States: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP.
- IDLE, address/data capture:
  - awready = !aw_held; wready = !w_held.
  - AW and W may handshake in the same or different cycles. Each is latched into a holding register and its flag is set.
- IDLE, transitions:
  - When both AW and W are held (including a hold completed this cycle) -> WR_ISSUE.
  - Otherwise, if arvalid and neither AW nor W is held -> accept AR and go to RD_ISSUE.
  - arready = !aw_held && !w_held && !awvalid && !wvalid. This gives write priority; simultaneous AR and AW/W means AR waits.
- WR_ISSUE:
  - When ready=1: drive we=1 for one cycle, with a = awaddr[REG_SHIFT+2:REG_SHIFT] and d = wdata. Clear the held flags and go to WR_RESP.
  - When ready=0: hold state; we stays 0.
- WR_RESP: bvalid=1, bresp=OKAY. On bready -> IDLE.
- RD_ISSUE:
  - When ready=1: drive rd=1 for one cycle and capture spo into rdata in that same cycle, i.e. the value before the FIFO pops. Go to RD_RESP.
- RD_RESP: rvalid=1, rresp=OKAY, rdata stable. On rready -> IDLE.
- Latency with ready=1:
  - Write: AW+W accepted at cycle N -> we at N+1 -> bvalid at N+2.
  - Read: AR accepted at N -> rd at N+1 -> rvalid at N+2.
- Strobe guarantees:
  - rd and we are never high together.
  - Each is high for exactly one cycle per transaction; there are no repeats while the response is stalled.
- a is held stable from the ISSUE state until the next accept.
- Back-pressure: bvalid/rvalid stay high until accepted. No new AW/W/AR is accepted while a response is pending.
- Address: bits outside the index field are ignored, with no decode error. Out-of-range registers alias.
- Reset mid-transaction: all state is discarded, no strobe is emitted, and the block returns to IDLE with reset values.

Optional Feature:
- Macro: AXI_LITE_UART_BRIDGE_WSTRB_CHECK_EN.
- Defined: if the wstrb bit for the UART lane is 0 (bit 3 when LENDIAN=0, bit 0 when LENDIAN=1), the write is not issued. We stays low, the FSM goes WR_ISSUE -> WR_RESP, and bresp=SLVERR (2'b10).
- Undefined: wstrb is ignored, every write issues we, and bresp=OKAY.

Decomposition:
- Package axi_lite_uart_bridge_pkg:
  - state enum (5 states);
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - UART_IDX_W=3.
- No sub-module. The AXI channel logic and FSM are one module of about 200 lines.

Test Plan:
- Write: AW(addr 0x0C) and W(0x03000000) in the same cycle -> we pulse at N+1 with a=3, d=0x03000000; bvalid at N+2; bresp=0.
- Split write: W at cycle 0, AW at cycle 5 -> exactly one we pulse at cycle 6; awready/wready deassert after each is held.
- Read RBR: spo=0x41000000 at a=0 -> one rd pulse; rdata=0x41000000; hold rready=0 for 10 cycles -> rd not repeated, rdata stable.
- Simultaneous AW+W+AR -> write completes first (we, then bvalid); the read's rd follows only after bready.
- ready=0 for 4 cycles in WR_ISSUE -> we asserted only in the first cycle with ready=1. Assert rst_n=0 mid-RD_ISSUE -> no rd pulse and all outputs return to reset values.
- With WSTRB_CHECK_EN, wstrb=4'b0001 and LENDIAN=0 -> no we pulse, bresp=2'b10. Without the macro -> we pulses and bresp=2'b00.
